// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix row/column lines plus the confirmed-key outputs.
// The master modport is the scanner; the slave modport is the keypad/consumer side.
interface keypad_scanner_if;
    logic [2:0] KEY_COL;
    logic [3:0] KEY_ROW;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  KEY_COL,
        output KEY_ROW,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output KEY_COL,
        input  KEY_ROW,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with frame-level debounce and one key_valid pulse per press.
// Optional macro KEYPAD_AUTO_REPEAT_EN adds held-key auto-repeat pulses.
//
// state    | meaning
// IDLE     | no key confirmed, waiting for a single-key frame
// DEBOUNCE | candidate key seen, counting identical frames
// PRESSED  | key confirmed, key_held high
// RELEASE  | confirmed key missing, counting non-matching frames
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 5
`ifdef KEYPAD_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 125,
    parameter int REPEAT_RATE     = 25
`endif
) (
    input  logic              clk_2,
    input  logic              rst_n,
    keypad_scanner_if.master  kp
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [DW-1:0] div;
    logic [3:0]    row;
    logic [3:0]    acc_code;
    logic          acc_any, acc_multi;

    logic [1:0]    col_cnt;
    logic [3:0]    col_idx, row_code, frm_code;
    logic          now_any, frm_any, frm_multi;
    logic          sample, frame_end, frame_key;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, rcnt, rcnt_nx;
    logic [3:0]    cand, cand_nx, code_q, code_nx;
    logic          valid_q, valid_nx, held_q, held_nx;
    logic          match;

`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int HW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
    localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE);
    logic [HW-1:0] hcnt, hcnt_nx;
    logic          rep, rep_nx;
`endif

    assign sample    = (div == DIV_LAST);
    assign frame_end = sample & row[3];

    // Per-row decode folded into the running frame accumulator.
    always_comb begin
        col_cnt = {1'b0, kp.KEY_COL[0]} + {1'b0, kp.KEY_COL[1]} + {1'b0, kp.KEY_COL[2]};
        now_any = |kp.KEY_COL;
        case (kp.KEY_COL)
            3'b100:  col_idx = 4'd0;
            3'b010:  col_idx = 4'd1;
            3'b001:  col_idx = 4'd2;
            default: col_idx = 4'd0;
        endcase
        row_code = 4'd0;
        if (row[0])      row_code = 4'd1 + col_idx;
        else if (row[1]) row_code = 4'd4 + col_idx;
        else if (row[2]) row_code = 4'd7 + col_idx;
        else if (col_idx == 4'd0) row_code = 4'd10;
        else if (col_idx == 4'd1) row_code = 4'd0;
        else             row_code = 4'd11;
        frm_any   = acc_any | now_any;
        frm_multi = acc_multi | (col_cnt > 2'd1) | (acc_any & now_any);
        frm_code  = now_any ? row_code : acc_code;
        frame_key = frm_any & ~frm_multi;
    end

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            div       <= '0;
            row       <= 4'b0001;
            acc_code  <= '0;
            acc_any   <= 1'b0;
            acc_multi <= 1'b0;
        end else if (sample) begin
            div <= '0;
            row <= {row[2:0], row[3]};
            if (row[3]) begin
                acc_code  <= '0;
                acc_any   <= 1'b0;
                acc_multi <= 1'b0;
            end else begin
                acc_code  <= frm_code;
                acc_any   <= frm_any;
                acc_multi <= frm_multi;
            end
        end else begin
            div <= div + DW'(1);
        end
    end

    assign match = frame_key & (frm_code == code_q);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rcnt_nx  = rcnt;
        cand_nx  = cand;
        code_nx  = code_q;
        valid_nx = 1'b0;
        held_nx  = held_q;
`ifdef KEYPAD_AUTO_REPEAT_EN
        hcnt_nx  = hcnt;
        rep_nx   = rep;
`endif
        if (frame_end) begin
            case (state)
                IDLE: if (frame_key) begin
                    cand_nx = frm_code;
                    if (CNT_LAST == CW'(1)) begin
                        state_nx = PRESSED;
                        code_nx  = frm_code;
                        valid_nx = 1'b1;
                        held_nx  = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = DEBOUNCE;
                        cnt_nx   = CW'(1);
                    end
                end
                DEBOUNCE: if (frame_key && frm_code == cand) begin
                    if (cnt + CW'(1) == CNT_LAST) begin
                        state_nx = PRESSED;
                        code_nx  = cand;
                        valid_nx = 1'b1;
                        held_nx  = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end else begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
                PRESSED: if (match) begin
                    rcnt_nx = '0;
`ifdef KEYPAD_AUTO_REPEAT_EN
                    if (hcnt + HW'(1) == (rep ? RATE_LAST : DELAY_LAST)) begin
                        valid_nx = 1'b1;
                        hcnt_nx  = '0;
                        rep_nx   = 1'b1;
                    end else begin
                        hcnt_nx = hcnt + HW'(1);
                    end
`endif
                end else begin
`ifdef KEYPAD_AUTO_REPEAT_EN
                    hcnt_nx = '0;
                    rep_nx  = 1'b0;
`endif
                    if (CNT_LAST == CW'(1)) begin
                        state_nx = IDLE;
                        held_nx  = 1'b0;
                        rcnt_nx  = '0;
                    end else begin
                        state_nx = RELEASE;
                        rcnt_nx  = CW'(1);
                    end
                end
                RELEASE: if (match) begin
                    state_nx = PRESSED;
                    rcnt_nx  = '0;
                end else if (rcnt + CW'(1) == CNT_LAST) begin
                    state_nx = IDLE;
                    held_nx  = 1'b0;
                    rcnt_nx  = '0;
                end else begin
                    rcnt_nx = rcnt + CW'(1);
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rcnt    <= '0;
            cand    <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
            hcnt    <= '0;
            rep     <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            rcnt    <= rcnt_nx;
            cand    <= cand_nx;
            code_q  <= code_nx;
            valid_q <= valid_nx;
            held_q  <= held_nx;
`ifdef KEYPAD_AUTO_REPEAT_EN
            hcnt    <= hcnt_nx;
            rep     <= rep_nx;
`endif
        end
    end

    assign kp.KEY_ROW   = row;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle frames).
// A keypad model drives KEY_COL from the active row; expected pulses are queued with their cycle.
module tb_keypad_scanner;
    localparam int FR = 16;

    logic clk_2 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_2 = ~clk_2;

    keypad_scanner_if kp();

    logic [3:0] press_rows = 4'b0000;
    logic [2:0] press_cols = 3'b000;
    assign kp.KEY_COL = (|(kp.KEY_ROW & press_rows)) ? press_cols : 3'b000;

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_FRAMES(3)
`ifdef KEYPAD_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY(4),
        .REPEAT_RATE(2)
`endif
    ) dut (
        .clk_2(clk_2),
        .rst_n(rst_n),
        .kp(kp.master)
    );

    typedef struct {
        logic [3:0] code;
        int         at;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk_2) cyc <= cyc + 1;

    always @(negedge clk_2) begin
        if (rst_n && kp.key_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse code=%0d cyc=%0d", kp.key_code, cyc);
            end else begin
                e = sbq.pop_front();
                if (kp.key_code !== e.code || cyc != e.at) begin
                    errors++;
                    $display("FAIL pulse actual code=%0d cyc=%0d required code=%0d cyc=%0d",
                             kp.key_code, cyc, e.code, e.at);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (n * FR) @(negedge clk_2);
    endtask

    task automatic press(input logic [3:0] rows, input logic [2:0] cols);
        press_rows = rows;
        press_cols = cols;
    endtask

    task automatic expect_pulse(input logic [3:0] code, input int nfr);
        sbq.push_back('{code: code, at: cyc + nfr * FR});
    endtask

    typedef struct {
        logic [3:0] rows;
        logic [2:0] cols;
        logic [3:0] code;
    } key_t;

    key_t keys[4];

    initial begin
        keys[0] = '{rows: 4'b0001, cols: 3'b100, code: 4'd1};
        keys[1] = '{rows: 4'b0100, cols: 3'b001, code: 4'd9};
        keys[2] = '{rows: 4'b1000, cols: 3'b100, code: 4'd10};
        keys[3] = '{rows: 4'b1000, cols: 3'b010, code: 4'd0};

        repeat (3) @(negedge clk_2);
        check("rst_row", kp.KEY_ROW, 4'b0001);
        check("rst_code", kp.key_code, 0);
        check("rst_valid", kp.key_valid, 0);
        check("rst_held", kp.key_held, 0);
        rst_n = 1'b1;

        // Idle scan: each row held for four cycles.
        for (int i = 0; i < FR; i++) begin
            check("row_scan", kp.KEY_ROW, 4'b0001 << (i / 4));
            @(negedge clk_2);
        end
        frames(9);
        check("idle_code", kp.key_code, 0);
        check("idle_held", kp.key_held, 0);

        // Key '2' for five frames, then release.
        press(4'b0001, 3'b010);
        expect_pulse(4'd2, 3);
        frames(5);
        check("k2_code", kp.key_code, 2);
        check("k2_held", kp.key_held, 1);
        press(4'b0000, 3'b000);
        frames(2);
        check("k2_release_early", kp.key_held, 1);
        frames(1);
        check("k2_release", kp.key_held, 0);
        check("k2_code_kept", kp.key_code, 2);

        // Bounce: 2 on, 1 off, 2 on leaves DEBOUNCE at count 2; one more frame confirms.
        press(4'b0001, 3'b010);
        frames(2);
        press(4'b0000, 3'b000);
        frames(1);
        press(4'b0001, 3'b010);
        frames(2);
        check("bounce_no_held", kp.key_held, 0);
        expect_pulse(4'd2, 1);
        frames(1);
        check("bounce_held", kp.key_held, 1);
        press(4'b0000, 3'b000);
        frames(3);
        check("bounce_release", kp.key_held, 0);

        // Multi-key frames never confirm.
        press(4'b0001, 3'b110);
        frames(6);
        check("multi_row_code", kp.key_code, 2);
        check("multi_row_held", kp.key_held, 0);
        press(4'b0011, 3'b100);
        frames(3);
        check("multi_col_code", kp.key_code, 2);
        check("multi_col_held", kp.key_held, 0);
        press(4'b0000, 3'b000);
        frames(1);

        // Key code map spot checks.
        for (int k = 0; k < 4; k++) begin
            press(keys[k].rows, keys[k].cols);
            expect_pulse(keys[k].code, 3);
            frames(3);
            check("map_code", kp.key_code, keys[k].code);
            check("map_held", kp.key_held, 1);
            press(4'b0000, 3'b000);
            frames(3);
            check("map_release", kp.key_held, 0);
        end

        // '#' confirmed, then switch straight to '5'.
        press(4'b1000, 3'b001);
        expect_pulse(4'd11, 3);
        frames(4);
        check("hash_code", kp.key_code, 11);
        check("hash_held", kp.key_held, 1);
        press(4'b0010, 3'b010);
        expect_pulse(4'd5, 6);
        frames(2);
        check("switch_held_early", kp.key_held, 1);
        frames(1);
        check("switch_held_drop", kp.key_held, 0);
        check("switch_code_kept", kp.key_code, 11);
        frames(3);
        check("switch_code", kp.key_code, 5);
        check("switch_held", kp.key_held, 1);

        // One-cycle reset while PRESSED.
        @(negedge clk_2);
        rst_n = 1'b0;
        @(negedge clk_2);
        check("mid_rst_row", kp.KEY_ROW, 4'b0001);
        check("mid_rst_held", kp.key_held, 0);
        check("mid_rst_code", kp.key_code, 0);
        check("mid_rst_valid", kp.key_valid, 0);
        rst_n = 1'b1;
        expect_pulse(4'd5, 3);
        frames(3);
        check("post_rst_held", kp.key_held, 1);
        press(4'b0000, 3'b000);
        frames(3);
        check("post_rst_release", kp.key_held, 0);

`ifdef KEYPAD_AUTO_REPEAT_EN
        press(4'b0100, 3'b100);
        expect_pulse(4'd7, 3);
        expect_pulse(4'd7, 7);
        expect_pulse(4'd7, 9);
        expect_pulse(4'd7, 11);
        frames(12);
        press(4'b0000, 3'b000);
        frames(3);
        check("repeat_release", kp.key_held, 0);
`endif

        frames(1);
        check("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
